// File: rtl/sig_pkg.sv
// Shared definitions for the SHA-256 message block packer.
package sig_pkg;

    localparam int unsigned BLOCK_WORDS = 16;
    localparam int unsigned BLOCK_BITS  = 512;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD,
        EMIT
    } packer_state_t;

    // Padded message spans L bytes + 0x80 byte + 8 length bytes, rounded up to 64.
    function automatic logic [63:0] len_to_blocks(input logic [63:0] len);
        return ((len + 64'd8) >> 6) + 64'd1;
    endfunction

endpackage

// File: rtl/sig_block_packer_if.sv
// Command, FIFO and block handshakes of the block packer; slave is the packer side.
interface sig_block_packer_if
    import sig_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 32
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  fifo_valid;
    logic [31:0]           fifo_dout;
    logic                  fifo_re;
    logic                  blk_valid;
    logic                  blk_ready;
    logic [BLOCK_BITS-1:0] blk_data;
    logic                  blk_first;
    logic                  blk_last;

    modport slave (
        input  cmd_valid, cmd_len, fifo_valid, fifo_dout, blk_ready,
        output cmd_ready, fifo_re, blk_valid, blk_data, blk_first, blk_last
    );

    modport master (
        output cmd_valid, cmd_len, fifo_valid, fifo_dout, blk_ready,
        input  cmd_ready, fifo_re, blk_valid, blk_data, blk_first, blk_last
    );

endinterface

// File: rtl/sig_last_word_pad.sv
// Keeps the first r bytes of the final message word and appends the 0x80 pad byte.
module sig_last_word_pad
    import sig_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  r,
    output logic [31:0] padded
);

    always_comb begin
        padded = word;
        unique case (r)
            2'd1:    padded = {word[31:24], PAD_BYTE, 16'h0000};
            2'd2:    padded = {word[31:16], PAD_BYTE, 8'h00};
            2'd3:    padded = {word[31:8], PAD_BYTE};
            default: padded = word;
        endcase
    end

endmodule

// File: rtl/sig_block_packer.sv
// Packs FIFO message words into SHA-256 padded 512-bit blocks, one message per command.
module sig_block_packer
    import sig_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sig_block_packer_if.slave    bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] blk_count
);

    packer_state_t         state_q;
    logic [BLOCK_BITS-1:0] blk_buf_q;
    logic [3:0]            widx_q;
    logic [LEN_WIDTH-1:0]  words_left_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  blk_idx_q;
    logic [LEN_WIDTH-1:0]  last_blk_q;
    logic                  pad_done_q;
    logic                  blk_first_q;
    logic                  blk_last_q;
    logic [CNT_WIDTH-1:0]  blk_count_q;

    logic [63:0]          cmd_len64;
    logic [LEN_WIDTH-1:0] cmd_words;
    logic [LEN_WIDTH-1:0] cmd_last_blk;
    logic [63:0]          len_bits;
    logic [1:0]           r;
    logic                 fill_final;
    logic                 final_blk;
    logic                 at_last_slot;
    logic [31:0]          padded_word;
    logic [31:0]          fill_word;
    logic [31:0]          pad_word;
    logic [8:0]           word_lsb;

    sig_last_word_pad u_last_word_pad (
        .word   (bus.fifo_dout),
        .r      (r),
        .padded (padded_word)
    );

    always_comb begin
        cmd_len64    = 64'(bus.cmd_len);
        cmd_words    = LEN_WIDTH'((cmd_len64 + 64'd3) >> 2);
        cmd_last_blk = LEN_WIDTH'(len_to_blocks(cmd_len64) - 64'd1);
        len_bits     = 64'(len_q) << 3;
        r            = 2'(len_q);
        fill_final   = (words_left_q == LEN_WIDTH'(1));
        final_blk    = (blk_idx_q == last_blk_q);
        at_last_slot = (widx_q == 4'(BLOCK_WORDS - 1));
        // Word 0 sits in the top 32 bits of the block.
        word_lsb     = {~widx_q, 5'd0};
        fill_word    = (fill_final && (r != 2'd0)) ? padded_word : bus.fifo_dout;
        pad_word     = 32'h0;
        if (!pad_done_q) begin
            pad_word = {PAD_BYTE, 24'h000000};
        end else if (final_blk && (widx_q == 4'd14)) begin
            pad_word = len_bits[63:32];
        end else if (final_blk && at_last_slot) begin
            pad_word = len_bits[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            blk_buf_q    <= '0;
            widx_q       <= '0;
            words_left_q <= '0;
            len_q        <= '0;
            blk_idx_q    <= '0;
            last_blk_q   <= '0;
            pad_done_q   <= 1'b0;
            blk_first_q  <= 1'b0;
            blk_last_q   <= 1'b0;
            blk_count_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        len_q        <= bus.cmd_len;
                        words_left_q <= cmd_words;
                        last_blk_q   <= cmd_last_blk;
                        widx_q       <= '0;
                        blk_idx_q    <= '0;
                        pad_done_q   <= 1'b0;
                        state_q      <= (cmd_words != '0) ? FILL : PAD;
                    end
                end
                FILL: begin
                    if (bus.fifo_valid) begin
                        blk_buf_q[word_lsb +: 32] <= fill_word;
                        widx_q       <= widx_q + 4'd1;
                        words_left_q <= words_left_q - LEN_WIDTH'(1);
                        if (fill_final && (r != 2'd0)) begin
                            pad_done_q <= 1'b1;
                        end
                        if (at_last_slot) begin
                            state_q     <= EMIT;
                            blk_first_q <= (blk_idx_q == '0);
                            blk_last_q  <= 1'b0;
                        end else if (fill_final) begin
                            state_q <= PAD;
                        end
                    end
                end
                PAD: begin
                    blk_buf_q[word_lsb +: 32] <= pad_word;
                    widx_q     <= widx_q + 4'd1;
                    pad_done_q <= 1'b1;
                    if (at_last_slot) begin
                        state_q     <= EMIT;
                        blk_first_q <= (blk_idx_q == '0);
                        blk_last_q  <= final_blk;
                    end
                end
                EMIT: begin
                    if (bus.blk_ready) begin
                        blk_count_q <= blk_count_q + CNT_WIDTH'(1);
                        widx_q      <= '0;
                        blk_idx_q   <= blk_idx_q + LEN_WIDTH'(1);
                        blk_first_q <= 1'b0;
                        blk_last_q  <= 1'b0;
                        if (blk_last_q) begin
                            state_q <= IDLE;
                        end else if (words_left_q != '0) begin
                            state_q <= FILL;
                        end else begin
                            state_q <= PAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.fifo_re   = (state_q == FILL);
    assign bus.blk_valid = (state_q == EMIT);
    assign bus.blk_data  = blk_buf_q;
    assign bus.blk_first = blk_first_q;
    assign bus.blk_last  = blk_last_q;
    assign busy          = (state_q != IDLE);
    assign blk_count     = blk_count_q;

endmodule

// File: tb/tb_sig_block_packer.sv
// Randomized bench for sig_block_packer against a byte-level SHA-256 padding model.
module tb_sig_block_packer;
    import sig_pkg::*;

    localparam int unsigned LW = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          busy;
    logic [CW-1:0] blk_count;

    sig_block_packer_if #(.LEN_WIDTH(LW)) bus ();

    sig_block_packer #(
        .LEN_WIDTH (LW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .blk_count (blk_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    byte unsigned  msg[$];
    logic [31:0]   fifo_q[$];
    logic [511:0]  blk_hist[$];
    logic [CW-1:0] exp_count;

    task automatic idle_inputs();
        bus.cmd_valid  = 1'b0;
        bus.cmd_len    = '0;
        bus.fifo_valid = 1'b0;
        bus.fifo_dout  = '0;
        bus.blk_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        exp_count = '0;
    endtask

    task automatic gen_msg(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    // Sends msg as one command and checks every block against the padded byte stream.
    task automatic run_msg(input string name, input int vpct, input int rpct,
                           input bit toggle, input bit stall5, input bit noise);
        byte unsigned pad[$];
        logic [63:0]  lbits;
        logic [511:0] e, prev_data;
        logic [31:0]  w;
        int len, nw, n_exp, blocks, pops, hold, cyc, waitc;
        bit fin, prev_valid, prev_acc, valid, ready;

        len = msg.size();
        pad = msg;
        pad.push_back(8'h80);
        while ((pad.size() % 64) != 56) pad.push_back(8'h00);
        lbits = 64'(len) * 64'd8;
        for (int k = 7; k >= 0; k--) pad.push_back(lbits[8*k +: 8]);
        n_exp = pad.size() / 64;

        nw = (len + 3) / 4;
        fifo_q.delete();
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 4; j++) begin
                w[31-8*j -: 8] = (4*i + j < len) ? msg[4*i+j] : 8'($urandom);
            end
            fifo_q.push_back(w);
        end
        fifo_q.push_back($urandom);
        fifo_q.push_back($urandom);
        blk_hist.delete();

        waitc = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(len);

        blocks = 0; pops = 0; hold = 0; cyc = 0; fin = 0;
        prev_valid = 0; prev_acc = 0; prev_data = '0;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (prev_valid && !prev_acc) begin
                total++;
                if (bus.blk_valid !== 1'b1 || bus.blk_data !== prev_data) begin
                    bad++;
                    $display("FAIL %s hold_stable: valid=%b data changed=%b required valid=1 unchanged",
                             name, bus.blk_valid, bus.blk_data !== prev_data);
                end
            end
            if (bus.blk_valid === 1'b1) begin
                total++;
                if (bus.fifo_re !== 1'b0) begin
                    bad++;
                    $display("FAIL %s re_in_emit: fifo_re=%b required 0", name, bus.fifo_re);
                end
            end
            if (busy === 1'b1) begin
                total++;
                if (bus.cmd_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s ready_busy: cmd_ready=%b required 0", name, bus.cmd_ready);
                end
            end
            if (stall5 && bus.blk_valid === 1'b1 && !prev_valid) hold = 5;
            if (hold > 0) begin
                ready = 1'b0;
                hold--;
            end else begin
                ready = ($urandom_range(99) < rpct);
            end
            valid = toggle ? (cyc % 2 == 0) : ($urandom_range(99) < vpct);
            if (fifo_q.size() == 0) valid = 1'b0;
            bus.fifo_valid = valid;
            bus.fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 32'($urandom);
            bus.blk_ready  = ready;
            bus.cmd_valid  = noise && (busy === 1'b1) && $urandom_range(1) == 1;
            bus.cmd_len    = LW'($urandom_range(300));

            if (bus.fifo_re === 1'b1 && valid) begin
                pops++;
                void'(fifo_q.pop_front());
            end
            if (bus.blk_valid === 1'b1 && ready) begin
                e = '0;
                if (blocks < n_exp) begin
                    for (int i = 0; i < 64; i++) e[511-8*i -: 8] = pad[blocks*64+i];
                end
                total++;
                if (bus.blk_data !== e) begin
                    bad++;
                    $display("FAIL %s block%0d_data: got %h required %h", name, blocks,
                             bus.blk_data, e);
                end
                total++;
                if (bus.blk_first !== (blocks == 0) || bus.blk_last !== (blocks == n_exp - 1)) begin
                    bad++;
                    $display("FAIL %s block%0d_flags: first=%b last=%b required first=%b last=%b",
                             name, blocks, bus.blk_first, bus.blk_last, blocks == 0,
                             blocks == n_exp - 1);
                end
                blk_hist.push_back(bus.blk_data);
                exp_count = exp_count + CW'(1);
                blocks++;
                if (bus.blk_last === 1'b1 || blocks >= n_exp + 2) fin = 1;
            end
            prev_valid = (bus.blk_valid === 1'b1);
            prev_acc   = prev_valid && ready;
            prev_data  = bus.blk_data;
        end

        if (!fin) begin
            total++;
            bad++;
            $display("FAIL %s timeout: blocks=%0d required %0d", name, blocks, n_exp);
            apply_reset();
        end else begin
            @(negedge clk);
            idle_inputs();
            total++;
            if (blocks != n_exp) begin
                bad++;
                $display("FAIL %s block_total: got %0d required %0d", name, blocks, n_exp);
            end
            total++;
            if (pops != nw) begin
                bad++;
                $display("FAIL %s pops: got %0d required %0d", name, pops, nw);
            end
            total++;
            if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL %s back_idle: cmd_ready=%b busy=%b required 1 0", name,
                         bus.cmd_ready, busy);
            end
            total++;
            if (blk_count !== exp_count) begin
                bad++;
                $display("FAIL %s blk_count: got %0d required %0d", name, blk_count, exp_count);
            end
        end
    endtask

    task automatic check_word(input string name, input int b, input int idx, input logic [31:0] req);
        logic [511:0] d;
        logic [31:0]  got;
        d   = (b < blk_hist.size()) ? blk_hist[b] : 'x;
        got = d[511-32*idx -: 32];
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s blk%0d_word%0d: got %h required %h", name, b, idx, got, req);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (bus.cmd_ready !== 1'b1 || bus.fifo_re !== 1'b0 || bus.blk_valid !== 1'b0 ||
            bus.blk_data !== '0 || bus.blk_first !== 1'b0 || bus.blk_last !== 1'b0 ||
            busy !== 1'b0 || blk_count !== '0) begin
            bad++;
            $display("FAIL reset_values: ready=%b re=%b valid=%b data0=%b first=%b last=%b busy=%b cnt=%0d required 1 0 0 1 0 0 0 0",
                     bus.cmd_ready, bus.fifo_re, bus.blk_valid, bus.blk_data == '0,
                     bus.blk_first, bus.blk_last, busy, blk_count);
        end
    endtask

    task automatic test_empty_message();
        gen_msg(0);
        run_msg("len0", 100, 100, 0, 0, 0);
        check_word("len0", 0, 0, 32'h80000000);
        check_word("len0", 0, 15, 32'h0);
    endtask

    task automatic test_short_message();
        gen_msg(3);
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_msg("len3", 100, 100, 0, 0, 0);
        check_word("len3", 0, 0, 32'h61626380);
        check_word("len3", 0, 14, 32'h0);
        check_word("len3", 0, 15, 32'h00000018);
    endtask

    task automatic test_one_block_boundary();
        gen_msg(55);
        msg[52] = 8'hAA; msg[53] = 8'hBB; msg[54] = 8'hCC;
        run_msg("len55", 80, 70, 0, 0, 1);
        check_word("len55", 0, 13, 32'hAABBCC80);
        check_word("len55", 0, 15, 32'h000001B8);
    endtask

    task automatic test_two_block_boundary();
        gen_msg(56);
        run_msg("len56", 100, 100, 0, 0, 0);
        check_word("len56", 0, 14, 32'h80000000);
        check_word("len56", 0, 15, 32'h0);
        check_word("len56", 1, 0, 32'h0);
        check_word("len56", 1, 15, 32'h000001C0);
    endtask

    task automatic test_stall();
        gen_msg(64);
        run_msg("len64_stall", 100, 100, 1, 1, 1);
        check_word("len64_stall", 1, 0, 32'h80000000);
        check_word("len64_stall", 1, 15, 32'h00000200);
    endtask

    task automatic test_reset_mid_fill();
        int waitc;
        gen_msg(100);
        waitc = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(100);
        repeat (5) begin
            @(negedge clk);
            bus.cmd_valid  = 1'b0;
            bus.fifo_valid = 1'b1;
            bus.fifo_dout  = $urandom;
        end
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        total++;
        if (bus.blk_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || busy !== 1'b0 ||
            blk_count !== '0) begin
            bad++;
            $display("FAIL reset_mid_fill: valid=%b ready=%b busy=%b cnt=%0d required 0 1 0 0",
                     bus.blk_valid, bus.cmd_ready, busy, blk_count);
        end
        reset     = 1'b0;
        exp_count = '0;
        gen_msg(4);
        msg[0] = 8'h01; msg[1] = 8'h02; msg[2] = 8'h03; msg[3] = 8'h04;
        run_msg("len4_after_reset", 100, 100, 0, 0, 0);
        check_word("len4_after_reset", 0, 0, 32'h01020304);
        check_word("len4_after_reset", 0, 1, 32'h80000000);
        check_word("len4_after_reset", 0, 15, 32'h00000020);
    endtask

    task automatic test_random();
        int lens[6] = '{63, 64, 119, 120, 1, 2};
        foreach (lens[i]) begin
            gen_msg(lens[i]);
            run_msg($sformatf("edge_len%0d", lens[i]), 60, 60, 0, 0, 1);
        end
        for (int i = 0; i < 10; i++) begin
            gen_msg($urandom_range(200));
            run_msg($sformatf("rand%0d_len%0d", i, msg.size()), $urandom_range(30, 100),
                    $urandom_range(30, 100), 0, 0, 1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            gen_msg($urandom_range(150));
            run_msg($sformatf("b2b%0d_len%0d", i, msg.size()), 100, 100, 0, 0, 0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        exp_count = '0;
        idle_inputs();
        test_reset();
        test_empty_message();
        test_short_message();
        test_one_block_boundary();
        test_two_block_boundary();
        test_stall();
        test_random();
        test_back_to_back();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
